byte_striper: RTL

// - Transmit-side counterpart of the lane mux/unstripping path: takes a serial 8-bit byte

---
 rtl/byte_striper.sv | 109 ++++++++++
 1 files changed

// File: rtl/byte_striper.sv
// byte_striper: packs a serial byte stream, MSB first, into 32-bit words.
// Completed words go to lane0 and lane1 in turn, starting with lane0.
// Each new word raises valid0 or valid1 for exactly one cycle.
module byte_striper #(
  parameter int BYTE_W = 8,
  parameter int LANE_W = 32  // must equal 4*BYTE_W
) (
  input  logic              clk,
  input  logic              reset,     // asynchronous, active-low
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic [LANE_W-1:0] lane0,
  output logic [LANE_W-1:0] lane1,
  output logic              valid0,
  output logic              valid1,
  output logic              sel_lane
);

  localparam int PART_W = 3 * BYTE_W;

  // The state is the index of the byte awaited next within the current word.
  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PART_W-1:0]   partial_q, partial_d;
  logic                sel_q, sel_d;
  logic [LANE_W-1:0]   lane0_q, lane0_d;
  logic [LANE_W-1:0]   lane1_q, lane1_d;
  logic                valid0_q, valid0_d;
  logic                valid1_q, valid1_d;
  logic [LANE_W-1:0]   word;

  // The word is complete once byte 3 arrives; byte 3 fills the least significant bits.
  assign word = {partial_q, data_in};

  // Next-state logic: accept a byte whenever valid_in is high. Otherwise hold everything.
  always_comb begin
    state_d   = state_q;
    partial_d = partial_q;
    sel_d     = sel_q;
    lane0_d   = lane0_q;
    lane1_d   = lane1_q;
    valid0_d  = 1'b0;
    valid1_d  = 1'b0;
    if (valid_in) begin
      unique case (state_q)
        B0: begin
          partial_d[PART_W-1 -: BYTE_W] = data_in;
          state_d = B1;
        end
        B1: begin
          partial_d[2*BYTE_W-1 -: BYTE_W] = data_in;
          state_d = B2;
        end
        B2: begin
          partial_d[BYTE_W-1:0] = data_in;
          state_d = B3;
        end
        B3: begin
          // Deliver the word to the selected lane. The other lane keeps its value.
          if (sel_q) begin
            lane1_d  = word;
            valid1_d = 1'b1;
          end else begin
            lane0_d  = word;
            valid0_d = 1'b1;
          end
          sel_d     = ~sel_q;
          partial_d = '0;
          state_d   = B0;
        end
        default: state_d = B0;
      endcase
    end
  end

  // State registers. Reset clears them at once and discards any partly built word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= B0;
      partial_q <= '0;
      sel_q     <= 1'b0;
      lane0_q   <= '0;
      lane1_q   <= '0;
      valid0_q  <= 1'b0;
      valid1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      partial_q <= partial_d;
      sel_q     <= sel_d;
      lane0_q   <= lane0_d;
      lane1_q   <= lane1_d;
      valid0_q  <= valid0_d;
      valid1_q  <= valid1_d;
    end
  end

  assign lane0    = lane0_q;
  assign lane1    = lane1_q;
  assign valid0   = valid0_q;
  assign valid1   = valid1_q;
  assign sel_lane = sel_q;

endmodule
